fifo_write_arbiter: RTL and testbench

Round-robin write arbiter that shares one `fifo_buffer` write port among `NUM_REQ` requesters (e.g. the command echo path, the status reporter and the test-pattern generator feeding the UART TX FIFO). Each requester offers bytes with a valid/ready handshake and marks packet ends with `last`. A packet, once started, is written contiguously without interleaving from other requesters. An idle-timeout recovers the port from a requester that stalls mid-packet.

---
 rtl/fifo_write_arbiter.sv | 129 ++++++++++++
 tb/tb_fifo_write_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin, packet-locking arbiter sharing one FIFO write port.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_n_i      synchronous active-low reset; also gates every handshake output
//   req_valid_i  per-requester byte-offered flags
//   req_last_i   per-requester end-of-packet flags
//   req_data_i   requester i's byte in slice [i*WIDTH +: WIDTH]
//   req_ready_o  one-hot accept strobe, same cycle as the FIFO write
//   fifo_full_i  FIFO full flag; no write is issued while it is high
//   fifo_wr_en_o FIFO write enable
//   fifo_data_o  FIFO write data
//   grant_id_o   selected requester (round-robin pointer when nobody is eligible)
//   locked_o     high while a multi-byte packet holds the port
//   abort_o      one-cycle pulse when a stalled packet is timed out
module fifo_write_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    input  logic [NUM_REQ-1:0]         req_last_i,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    input  logic                       fifo_full_i,
    output logic                       fifo_wr_en_o,
    output logic [WIDTH-1:0]           fifo_data_o,
    output logic [$clog2(NUM_REQ)-1:0] grant_id_o,
    output logic                       locked_o,
    output logic                       abort_o
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE, LOCKED} state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]   idle_cnt_q, idle_cnt_d;
    logic            abort_q, abort_d;
    logic [IW-1:0]   cand;
    logic            has_cand;
    logic            beat;
    logic            owner_idle;
    logic            timeout_hit;

    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return IW'(s);
    endfunction

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] p);
        return (int'(p) == NUM_REQ - 1) ? '0 : p + 1'b1;
    endfunction

    // Scan from the far end back towards rr_ptr so the last hit is the first
    // valid requester in round-robin order. A locked packet pins the owner.
    always_comb begin
        cand     = (state_q == LOCKED) ? owner_q : rr_ptr_q;
        has_cand = (state_q == LOCKED);
        if (state_q == IDLE) begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                if (req_valid_i[wrap_add(rr_ptr_q, k)]) begin
                    cand     = wrap_add(rr_ptr_q, k);
                    has_cand = 1'b1;
                end
            end
        end
    end

    assign beat        = rst_n_i && has_cand && req_valid_i[cand] && !fifo_full_i;
    assign owner_idle  = (state_q == LOCKED) && !req_valid_i[owner_q];
    assign timeout_hit = owner_idle && (idle_cnt_q == CW'(TIMEOUT - 1));

    assign fifo_wr_en_o = beat;
    assign req_ready_o  = beat ? (NUM_REQ'(1) << cand) : '0;
    assign fifo_data_o  = (rst_n_i && has_cand) ? req_data_i[int'(cand)*WIDTH +: WIDTH] : '0;
    assign grant_id_o   = rst_n_i ? cand : '0;
    assign locked_o     = rst_n_i && (state_q == LOCKED);
    assign abort_o      = rst_n_i && abort_q;

    // An owner that is valid but blocked by a full FIFO is stalled, not idle,
    // so only genuinely missing data advances the timeout counter.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        idle_cnt_d = idle_cnt_q;
        abort_d    = 1'b0;
        if (beat && req_last_i[cand]) begin
            state_d  = IDLE;
            rr_ptr_d = wrap_inc(cand);
        end else if (beat) begin
            state_d    = LOCKED;
            owner_d    = cand;
            idle_cnt_d = '0;
        end else if (timeout_hit) begin
            state_d    = IDLE;
            rr_ptr_d   = wrap_inc(owner_q);
            idle_cnt_d = '0;
            abort_d    = 1'b1;
        end else if (owner_idle) begin
            idle_cnt_d = idle_cnt_q + 1'b1;
        end else if (state_q == LOCKED) begin
            idle_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            idle_cnt_q <= '0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            idle_cnt_q <= idle_cnt_d;
            abort_q    <= abort_d;
        end
    end
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter: directed and random checks of fifo_write_arbiter against a reference model.
module tb_fifo_write_arbiter;
    localparam int N     = 4;
    localparam int W     = 8;
    localparam int TO    = 4;
    localparam int DEPTH = 16;
    localparam int IW    = $clog2(N);

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   valid = '0;
    logic [N-1:0]   last = '0;
    logic [N*W-1:0] data = '0;
    logic           full = 1'b0;
    logic           rd = 1'b0;
    logic [N-1:0]   ready;
    logic           wr_en;
    logic [W-1:0]   fdata;
    logic [IW-1:0]  gid;
    logic           locked;
    logic           abort;

    int checks = 0;
    int errors = 0;

    // reference model state
    bit m_lock = 0;
    int m_owner = 0;
    int m_ptr = 0;
    int m_idle = 0;
    bit m_abort = 0;
    int exp_count = 0;
    logic [N-1:0] e_ready;
    bit dut_abort;
    logic [W-1:0] fq[$];

    fifo_write_arbiter #(.NUM_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .req_valid_i(valid), .req_last_i(last),
        .req_data_i(data), .req_ready_o(ready), .fifo_full_i(full),
        .fifo_wr_en_o(wr_en), .fifo_data_o(fdata), .grant_id_o(gid),
        .locked_o(locked), .abort_o(abort)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: predict outputs from the current inputs, compare, then
    // advance the FIFO and the model across the rising edge.
    task automatic tick();
        int cand;
        bit has;
        bit e_wr;
        logic [W-1:0] e_data;
        bit dut_wr;
        logic [W-1:0] dut_d;
        full = (fq.size() >= DEPTH - 1);
        #2;
        has  = m_lock;
        cand = m_lock ? m_owner : m_ptr;
        if (!m_lock) begin
            for (int j = 0; j < N; j++) begin
                if (!has && valid[(m_ptr + j) % N]) begin
                    has  = 1;
                    cand = (m_ptr + j) % N;
                end
            end
        end
        e_wr    = rst_n && has && valid[cand] && !full;
        e_ready = e_wr ? N'(1 << cand) : '0;
        e_data  = (rst_n && has) ? data[cand*W +: W] : '0;
        chk("wr_en", 32'(wr_en), 32'(e_wr));
        chk("ready", 32'(ready), 32'(e_ready));
        if (e_wr || !rst_n) chk("data", 32'(fdata), 32'(e_data));
        chk("grant_id", 32'(gid), rst_n ? 32'(cand) : 32'd0);
        chk("locked", 32'(locked), 32'(rst_n && m_lock));
        chk("abort", 32'(abort), 32'(rst_n && m_abort));
        dut_wr    = wr_en;
        dut_d     = fdata;
        dut_abort = abort;
        @(posedge clk);
        if (dut_wr) fq.push_back(dut_d);
        if (rd && fq.size() > 0) void'(fq.pop_front());
        if (e_wr) exp_count++;
        if (rd && exp_count > 0) exp_count--;
        if (!rst_n) begin
            m_lock = 0; m_owner = 0; m_ptr = 0; m_idle = 0; m_abort = 0;
        end else begin
            m_abort = 0;
            if (e_wr && last[cand]) begin
                m_lock = 0;
                m_ptr  = (cand + 1) % N;
            end else if (e_wr) begin
                m_lock  = 1;
                m_owner = cand;
                m_idle  = 0;
            end else if (m_lock && !valid[m_owner]) begin
                m_idle++;
                if (m_idle == TO) begin
                    m_abort = 1;
                    m_lock  = 0;
                    m_ptr   = (m_owner + 1) % N;
                    m_idle  = 0;
                end
            end else if (m_lock) begin
                m_idle = 0;
            end
        end
        #1;
    endtask

    initial begin
        int p;
        int n;
        @(posedge clk);
        #1;
        // reset held with every requester asserting
        rst_n = 0; valid = '1; last = '1; data = 32'h44332211;
        repeat (3) tick();
        rst_n = 1;
        tick();
        // round-robin of single-byte packets on 0, 2, 3
        rd = 1; valid = 4'b1101; last = '1; data = 32'h30200010;
        repeat (10) tick();
        // packet lock on requester 1 while requester 0 keeps asking
        p = 0;
        for (int i = 0; i < 20 && p < 3; i++) begin
            valid = 4'b0011;
            last  = {2'b00, p == 2, 1'b1};
            data  = {16'h0, 8'(8'hA1 + p), 8'h55};
            tick();
            if (e_ready[1]) p++;
        end
        chk("pkt_done", 32'(p), 32'd3);
        valid = 4'b0001; last = 4'b0001;
        repeat (2) tick();
        // FIFO full with three requesters pending
        rd = 0; valid = 4'b0111; last = '1; data = 32'h00C3C2C1;
        for (int i = 0; i < 40 && fq.size() < DEPTH - 1; i++) tick();
        chk("fill_level", 32'(fq.size()), 32'(DEPTH - 1));
        repeat (3) tick();
        rd = 1;
        tick();
        rd = 0;
        repeat (2) tick();
        chk("fifo_count", 32'(fq.size()), 32'(exp_count));
        rd = 1; valid = '0;
        repeat (20) tick();
        chk("drained", 32'(fq.size()), 32'(exp_count));
        // timeout: requester 2 starts a packet and goes silent
        valid = 4'b0100; last = '0; data = 32'h33222222;
        tick();
        valid = 4'b1000; last = 4'b1000;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            n++;
            tick();
            if (dut_abort) break;
        end
        chk("abort_delay", 32'(n), 32'd5);
        repeat (2) tick();
        // reset while locked on owner 3
        valid = 4'b1000; last = '0;
        tick();
        valid = '0;
        tick();
        rst_n = 0;
        tick();
        rst_n = 1;
        repeat (2) tick();
        valid = 4'b0010; last = 4'b0010; data = 32'h0000BB00;
        tick();
        // random traffic
        for (int i = 0; i < 600; i++) begin
            valid = N'($urandom);
            last  = N'($urandom);
            data  = $urandom;
            rd    = 1'($urandom_range(0, 1));
            rst_n = ($urandom_range(0, 63) != 0);
            tick();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
